// File: rtl/status_stash_pkg.sv
// rtl/status_stash_pkg.sv - flag bit positions and stash FSM state encoding
package status_stash_pkg;

    localparam int FLAG_C_BIT = 1;
    localparam int FLAG_Z_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SAVE_WR      = 3'd1,
        ST_RESTORE_RD   = 3'd2,
        ST_RESTORE_LOAD = 3'd3,
        ST_DONE         = 3'd4
    } stash_state_e;

endpackage

// File: rtl/status_stash.sv
// rtl/status_stash.sv - spills/reloads carry/zero flags to an in-memory LIFO
module status_stash
    import status_stash_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'hFFF0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  saveReq,
    input  logic                  restoreReq,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  flagCIn,
    input  logic                  flagZIn,
    output logic                  flagCOut,
    output logic                  flagZOut,
    output logic                  notLoad,
    output logic                  memReq,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memDataOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    input  logic                  memAck
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    stash_state_e     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             save_c_q, save_c_d;
    logic             save_z_q, save_z_d;
    logic             err_q, err_d;
    logic             out_c_q, out_c_d;
    logic             out_z_q, out_z_d;
    logic             unused_data_bits;

    // Only the two flag bits of the read word carry information.
    assign unused_data_bits = &{1'b0, memDataIn};

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            save_c_q <= 1'b0;
            save_z_q <= 1'b0;
            err_q    <= 1'b0;
            out_c_q  <= 1'b0;
            out_z_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            save_c_q <= save_c_d;
            save_z_q <= save_z_d;
            err_q    <= err_d;
            out_c_q  <= out_c_d;
            out_z_q  <= out_z_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        save_c_d = save_c_q;
        save_z_d = save_z_q;
        err_d    = err_q;
        out_c_d  = out_c_q;
        out_z_d  = out_z_q;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (saveReq) begin
                    if (ptr_q != PTR_W'(DEPTH)) begin
                        save_c_d = flagCIn;
                        save_z_d = flagZIn;
                        state_d  = ST_SAVE_WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (restoreReq) begin
                    if (ptr_q != '0) begin
                        state_d = ST_RESTORE_RD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SAVE_WR: begin
                if (memAck) begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = ST_DONE;
                end
            end
            ST_RESTORE_RD: begin
                if (memAck) begin
                    out_c_d = memDataIn[FLAG_C_BIT];
                    out_z_d = memDataIn[FLAG_Z_BIT];
                    ptr_d   = ptr_q - PTR_W'(1);
                    state_d = ST_RESTORE_LOAD;
                end
            end
            ST_RESTORE_LOAD: state_d = ST_DONE;
            ST_DONE:         state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset drops memReq immediately.
    always_comb begin
        memReq     = 1'b0;
        memWrite   = 1'b0;
        memAddr    = '0;
        memDataOut = '0;
        case (state_q)
            ST_SAVE_WR: begin
                memReq                 = 1'b1;
                memWrite               = 1'b1;
                memAddr                = BASE_ADDR + ADDR_WIDTH'(ptr_q);
                memDataOut[FLAG_C_BIT] = save_c_q;
                memDataOut[FLAG_Z_BIT] = save_z_q;
            end
            ST_RESTORE_RD: begin
                memReq  = 1'b1;
                memAddr = BASE_ADDR + ADDR_WIDTH'(ptr_q) - ADDR_WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_DONE) && err_q;
    assign notLoad  = (state_q != ST_RESTORE_LOAD);
    assign flagCOut = out_c_q;
    assign flagZOut = out_z_q;

endmodule

// File: tb/tb_status_stash.sv
// tb/tb_status_stash.sv - transaction-level LIFO model check of status_stash
module tb_status_stash;

    localparam int          DW    = 16;
    localparam int          AW    = 16;
    localparam logic [15:0] BASE  = 16'hFFF0;
    localparam int          DEPTH = 4;

    logic          clock = 1'b0;
    logic          notReset;
    logic          saveReq, restoreReq;
    logic          busy, done, error;
    logic          flagCIn, flagZIn, flagCOut, flagZOut, notLoad;
    logic          memReq, memWrite, memAck;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memDataOut, memDataIn;

    int checks = 0;
    int errors = 0;

    // Reference model: a stack of saved 2-bit flag words plus the last restored flags.
    logic [1:0] stack_q [$];
    logic       last_c, last_z;
    int         loads_expected = 0;
    int         loads_seen = 0;

    status_stash #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clock(clock), .notReset(notReset), .saveReq(saveReq), .restoreReq(restoreReq),
        .busy(busy), .done(done), .error(error), .flagCIn(flagCIn), .flagZIn(flagZIn),
        .flagCOut(flagCOut), .flagZOut(flagZOut), .notLoad(notLoad), .memReq(memReq),
        .memWrite(memWrite), .memAddr(memAddr), .memDataOut(memDataOut),
        .memDataIn(memDataIn), .memAck(memAck)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (notReset && !notLoad) loads_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_save(input logic c, input logic z, input int waits);
        logic [15:0] exp_addr;
        flagCIn = c;
        flagZIn = z;
        saveReq = 1'b1;
        @(negedge clock);
        saveReq = 1'b0;
        if (stack_q.size() == DEPTH) begin
            chk("save_full_memreq", memReq, 0);
            chk("save_full_done", done, 1);
            chk("save_full_error", error, 1);
        end else begin
            exp_addr = BASE + 16'(stack_q.size());
            for (int w = 0; w <= waits; w++) begin
                chk("save_memreq", memReq, 1);
                chk("save_memwrite", memWrite, 1);
                chk("save_addr", memAddr, exp_addr);
                chk("save_data", memDataOut, {30'd0, c, z});
                chk("save_flags_hold", {flagCOut, flagZOut}, {last_c, last_z});
                memAck = (w == waits);
                @(negedge clock);
            end
            memAck = 1'b0;
            stack_q.push_back({c, z});
            chk("save_done", done, 1);
            chk("save_error", error, 0);
            chk("save_memreq_off", memReq, 0);
        end
        @(negedge clock);
        chk("save_idle_busy", busy, 0);
        chk("save_idle_done", done, 0);
    endtask

    task automatic do_restore(input int waits, input bit use_raw, input logic [15:0] raw);
        logic [15:0] val;
        logic [15:0] exp_addr;
        restoreReq = 1'b1;
        @(negedge clock);
        restoreReq = 1'b0;
        if (stack_q.size() == 0) begin
            chk("restore_empty_memreq", memReq, 0);
            chk("restore_empty_done", done, 1);
            chk("restore_empty_error", error, 1);
        end else begin
            exp_addr = BASE + 16'(stack_q.size() - 1);
            val = use_raw ? raw : {14'($urandom), stack_q[stack_q.size()-1]};
            for (int w = 0; w <= waits; w++) begin
                memDataIn = val;
                chk("restore_memreq", memReq, 1);
                chk("restore_memwrite", memWrite, 0);
                chk("restore_addr", memAddr, exp_addr);
                chk("restore_noload", notLoad, 1);
                memAck = (w == waits);
                @(negedge clock);
            end
            memAck    = 1'b0;
            memDataIn = 16'($urandom);
            void'(stack_q.pop_back());
            last_c = val[1];
            last_z = val[0];
            loads_expected++;
            chk("restore_load_low", notLoad, 0);
            chk("restore_flag_c", flagCOut, last_c);
            chk("restore_flag_z", flagZOut, last_z);
            chk("restore_load_memreq", memReq, 0);
            @(negedge clock);
            chk("restore_done", done, 1);
            chk("restore_error", error, 0);
            chk("restore_load_high", notLoad, 1);
            chk("restore_flags_stable", {flagCOut, flagZOut}, {last_c, last_z});
        end
        @(negedge clock);
        chk("restore_idle_busy", busy, 0);
        chk("restore_idle_done", done, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_memreq"}, memReq, 0);
        chk({tag, "_memwrite"}, memWrite, 0);
        chk({tag, "_memaddr"}, memAddr, 0);
        chk({tag, "_memdata"}, memDataOut, 0);
        chk({tag, "_notload"}, notLoad, 1);
        chk({tag, "_flags"}, {flagCOut, flagZOut}, 0);
    endtask

    initial begin
        notReset   = 1'b0;
        saveReq    = 1'b0;
        restoreReq = 1'b0;
        flagCIn    = 1'b0;
        flagZIn    = 1'b0;
        memAck     = 1'b0;
        memDataIn  = '0;
        last_c     = 1'b0;
        last_z     = 1'b0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clock);
        @(negedge clock);
        notReset = 1'b1;
        @(negedge clock);

        // Save C=1 Z=0 with zero-wait memory, then restore it through a slow memory.
        do_save(1'b1, 1'b0, 0);
        flagCIn = 1'b0;
        flagZIn = 1'b1;
        do_restore(3, 1'b1, 16'h0002);

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < DEPTH + 1; i++) do_save(1'($urandom), 1'($urandom), i % 2);
        for (int i = 0; i < DEPTH; i++) do_restore(i % 3, 1'b0, 16'h0);
        do_restore(0, 1'b0, 16'h0);

        // Both requests high: save first, restore served after DONE.
        restoreReq = 1'b1;
        do_save(1'b1, 1'b1, 1);
        do_restore(0, 1'b0, 16'h0);

        // Only the low two bits of the read word are used.
        do_save(1'b1, 1'b0, 0);
        do_restore(0, 1'b1, 16'hFFFD);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) do_save(1'($urandom), 1'($urandom), $urandom_range(3, 0));
            else do_restore($urandom_range(3, 0), 1'b0, 16'h0);
        end

        // Reset in the middle of a restore read.
        while (stack_q.size() < 2) do_save(1'($urandom), 1'($urandom), 0);
        restoreReq = 1'b1;
        @(negedge clock);
        restoreReq = 1'b0;
        chk("midreset_memreq_before", memReq, 1);
        #2 notReset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        stack_q.delete();
        last_c = 1'b0;
        last_z = 1'b0;
        @(negedge clock);
        notReset = 1'b1;
        @(negedge clock);
        do_restore(0, 1'b0, 16'h0);
        do_save(1'b0, 1'b1, 0);
        do_restore(1, 1'b0, 16'h0);

        chk("load_pulse_count", loads_seen, loads_expected);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
